display_scan_ctrl: RTL and testbench

Sequencing controller for the two-digit seven-segment output of the Hamming decoder board. It latches the corrected word and syndrome on a valid strobe and debounces the user button. A button-driven mode FSM selects between time-multiplexed scanning of both digits and a single held digit. It sits between the decoder outputs and the pins, driving the seven-segment converters from latched values and registering the final seg/an.

---
 rtl/display_pkg.sv | 15 +
 rtl/display_scan_ctrl_btn_debounce.sv | 45 ++++
 rtl/display_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit seven-segment scan controller.
package display_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        BIN_ONLY = 2'd1,
        SIN_ONLY = 2'd2
    } mode_e;

    localparam logic [1:0] AN_OFF    = 2'b00;
    localparam logic [1:0] AN_SIN    = 2'b01;
    localparam logic [1:0] AN_BIN    = 2'b10;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/display_scan_ctrl_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// single-cycle pulse on every accepted 0->1 transition of the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic [CW-1:0] cnt;

    // Any disagreement between the synchronized input and the accepted level
    // must persist for the full window; a single agreeing sample restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                level <= sync_2;
                press <= sync_2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Drives the two-digit display of the Hamming decoder board: latches the
// decoder result, cycles display modes on button presses and scans the digits.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int REFRESH_CYCLES  = 27000,
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       data_valid,
    input  logic [3:0] bin,
    input  logic [2:0] sin,
    input  logic [6:0] seg_bin,
    input  logic [6:0] seg_sin,
    output logic [3:0] bin_q,
    output logic [2:0] sin_q,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam int            RW      = $clog2(REFRESH_CYCLES);
    localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_CYCLES - 1);

    mode_e         mode_q;
    mode_e         mode_d;
    logic          press;
    logic [RW-1:0] refresh_cnt;
    logic          digit_sel;
    logic [1:0]    an_d;
    logic [6:0]    seg_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .press (press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= SCAN;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (press) begin
            case (mode_q)
                SCAN:     mode_d = BIN_ONLY;
                BIN_ONLY: mode_d = SIN_ONLY;
                SIN_ONLY: mode_d = SCAN;
                default:  mode_d = SCAN;
            endcase
        end
    end

    // Free-running in every mode so that returning to SCAN keeps the phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_sel   <= 1'b0;
        end else if (refresh_cnt == REF_MAX) begin
            refresh_cnt <= '0;
            digit_sel   <= ~digit_sel;
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            sin_q <= '0;
            err   <= 1'b0;
        end else if (data_valid) begin
            bin_q <= bin;
            sin_q <= sin;
            err   <= (sin != 3'd0);
        end
    end

    always_comb begin
        an_d  = AN_SIN;
        seg_d = seg_sin;
        case (mode_q)
            BIN_ONLY: begin
                an_d  = AN_BIN;
                seg_d = seg_bin;
            end
            SIN_ONLY: begin
                an_d  = AN_SIN;
                seg_d = seg_sin;
            end
            default: begin
                if (digit_sel) begin
                    an_d  = AN_BIN;
                    seg_d = seg_bin;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_d;
            seg <= seg_d;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed self-checking bench for display_scan_ctrl with short refresh and
// debounce windows so every mode and the reset behaviour can be exercised.
module tb_display_scan_ctrl;
    import display_pkg::*;

    localparam int R = 4;
    localparam int D = 8;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       btn        = 1'b0;
    logic       data_valid = 1'b0;
    logic [3:0] bin        = 4'h0;
    logic [2:0] sin        = 3'd0;
    logic [6:0] seg_bin;
    logic [6:0] seg_sin;
    logic [3:0] bin_q;
    logic [2:0] sin_q;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    int errors      = 0;
    int checks      = 0;
    int edge_cnt    = 0;
    int press_count = 0;
    int press_edge  = -1;

    display_scan_ctrl #(
        .REFRESH_CYCLES (R),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .data_valid(data_valid),
        .bin       (bin),
        .sin       (sin),
        .seg_bin   (seg_bin),
        .seg_sin   (seg_sin),
        .bin_q     (bin_q),
        .sin_q     (sin_q),
        .seg       (seg),
        .an        (an),
        .err       (err)
    );

    // Stand-in converters with distinct, easily hand-computed patterns.
    assign seg_sin = {4'b1000, sin_q};
    assign seg_bin = {3'b011, bin_q};

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    always @(negedge clk) begin
        if (dut.press === 1'b1) begin
            press_count <= press_count + 1;
            press_edge  <= edge_cnt;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic dv, input logic [3:0] b, input logic [2:0] s);
        data_valid = dv;
        bin        = b;
        sin        = s;
    endtask

    // Digit lit after edge k of a scan that started at reset release.
    function automatic logic [1:0] scan_an(input int k);
        return ((((k - 1) / R) % 2) == 0) ? AN_SIN : AN_BIN;
    endfunction

    task automatic check_scan(input string tag, input logic [6:0] s_exp, input logic [6:0] b_exp);
        logic [1:0] a_exp;
        a_exp = scan_an(edge_cnt);
        checkOutput({tag, "_an"}, 32'(an), 32'(a_exp));
        checkOutput({tag, "_seg"}, 32'(seg), 32'((a_exp == AN_SIN) ? s_exp : b_exp));
    endtask

    task automatic press_button(input string tag, input int hold);
        int k0;
        int base;
        base = press_count;
        k0   = edge_cnt;
        btn  = 1'b1;
        step(hold);
        btn  = 1'b0;
        step(14);
        checkOutput({tag, "_count"}, 32'(press_count), 32'(base + 1));
        checkOutput({tag, "_edge"}, 32'(press_edge), 32'(k0 + 2 + D));
    endtask

    initial begin
        int base;

        $display("[TB] reset values");
        step(2);
        checkOutput("rst_an", 32'(an), 32'(AN_OFF));
        checkOutput("rst_seg", 32'(seg), 32'(SEG_BLANK));
        checkOutput("rst_bin_q", 32'(bin_q), 32'h0);
        checkOutput("rst_sin_q", 32'(sin_q), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        step(1);
        checkOutput("first_an", 32'(an), 32'(AN_SIN));

        $display("[TB] data latch and scanning");
        applyStimulus(1'b1, 4'hA, 3'd5);
        step(1);
        applyStimulus(1'b0, 4'h0, 3'd0);
        checkOutput("t1_bin_q", 32'(bin_q), 32'hA);
        checkOutput("t1_sin_q", 32'(sin_q), 32'h5);
        checkOutput("t1_err", 32'(err), 32'h1);
        checkOutput("t1_seg_old", 32'(seg), 32'h40);
        step(1);
        checkOutput("t1_seg_new", 32'(seg), 32'h45);
        for (int i = 0; i < 12; i++) begin
            step(1);
            check_scan("t1_scan", 7'h45, 7'h3A);
        end

        $display("[TB] short glitch");
        base = press_count;
        btn  = 1'b1;
        step(5);
        btn  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            check_scan("t3_scan", 7'h45, 7'h3A);
        end
        checkOutput("t3_no_press", 32'(press_count), 32'(base));

        $display("[TB] long press to BIN_ONLY");
        press_button("t2_press", 20);
        for (int i = 0; i < 8; i++) begin
            step(1);
            checkOutput("t2_an", 32'(an), 32'(AN_BIN));
            checkOutput("t2_seg", 32'(seg), 32'h3A);
        end

        $display("[TB] press to SIN_ONLY");
        press_button("t4a_press", 14);
        for (int i = 0; i < 8; i++) begin
            step(1);
            checkOutput("t4a_an", 32'(an), 32'(AN_SIN));
            checkOutput("t4a_seg", 32'(seg), 32'h45);
        end

        $display("[TB] clean syndrome in SIN_ONLY");
        applyStimulus(1'b1, 4'h3, 3'd0);
        step(1);
        applyStimulus(1'b0, 4'h0, 3'd0);
        checkOutput("t5_err", 32'(err), 32'h0);
        checkOutput("t5_sin_q", 32'(sin_q), 32'h0);
        checkOutput("t5_bin_q", 32'(bin_q), 32'h3);
        checkOutput("t5_seg_old", 32'(seg), 32'h45);
        step(1);
        checkOutput("t5_seg_new", 32'(seg), 32'h40);
        checkOutput("t5_an", 32'(an), 32'(AN_SIN));

        $display("[TB] press back to SCAN");
        press_button("t4b_press", 14);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_scan("t4b_scan", 7'h40, 7'h33);
        end

        $display("[TB] press to BIN_ONLY, then reset with button held");
        press_button("t4c_press", 14);
        btn = 1'b1;
        step(3);
        checkOutput("t6_pre_an", 32'(an), 32'(AN_BIN));
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_an", 32'(an), 32'(AN_OFF));
        checkOutput("t6_rst_seg", 32'(seg), 32'(SEG_BLANK));
        checkOutput("t6_rst_bin_q", 32'(bin_q), 32'h0);
        checkOutput("t6_rst_err", 32'(err), 32'h0);
        base = press_count;
        step(1);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            if (k <= 11) begin
                check_scan("t6_scan", 7'h40, 7'h30);
            end else begin
                checkOutput("t6_bin_an", 32'(an), 32'(AN_BIN));
                checkOutput("t6_bin_seg", 32'(seg), 32'h30);
            end
        end
        checkOutput("t6_press_count", 32'(press_count), 32'(base + 1));
        checkOutput("t6_press_edge", 32'(press_edge), 32'(2 + D));
        btn = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
